// File: rtl/traffic_pkg.sv
// Shared types for the intersection sensor conditioner and light controller.
package traffic_pkg;

  // MSB of the encoding is the debounced level, so it can be used directly as a flop output.
  typedef enum logic [1:0] {
    DB_LOW  = 2'b00,
    DB_RISE = 2'b01,
    DB_HIGH = 2'b10,
    DB_FALL = 2'b11
  } deb_state_t;

  typedef enum logic [1:0] {
    P_IDLE   = 2'b00,
    P_ACTIVE = 2'b01,
    P_REARM  = 2'b10
  } prio_state_t;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for one raw detector input.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic deb,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = ctr_width(DEB_TICKS);

  logic [1:0]    sync_q;
  logic          s;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign s   = sync_q[1];
  assign deb = state_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= DB_LOW;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    if (tick) begin
      if (s == deb) begin
        cnt_d   = '0;
        state_d = deb ? DB_HIGH : DB_LOW;
      end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
        cnt_d   = '0;
        state_d = deb ? DB_LOW : DB_HIGH;
        rise_c  = ~deb;
        fall_c  = deb;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = deb ? DB_FALL : DB_RISE;
      end
    end
  end

endmodule

// File: rtl/traffic_sensor_cond.sv
// Detector/emergency conditioner feeding the light controller: debounce, hold, priority FSM.
// Optional car counters enabled with `define TRAFFIC_STATS_EN.
module traffic_sensor_cond
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = 4,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned PRIO_TICKS = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             det_a_raw,
  input  logic             det_b_raw,
  input  logic             emerg_raw,
  input  logic             emerg_clr,
  input  logic             stats_clr,
  output logic             Ta,
  output logic             Tb,
  output logic             prio,
  output logic [CNT_W-1:0] cars_a,
  output logic [CNT_W-1:0] cars_b
);

  localparam int unsigned HW = ctr_width(HOLD_TICKS);
  localparam int unsigned TW = ctr_width(PRIO_TICKS);

  logic deb_a, rise_a_c, fall_a_c;
  logic deb_b, rise_b_c, fall_b_c;
  logic deb_e, rise_e_c, unused_fall_e_c;

  sensor_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(det_a_raw),
    .deb(deb_a), .rise_c(rise_a_c), .fall_c(fall_a_c)
  );

  sensor_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(det_b_raw),
    .deb(deb_b), .rise_c(rise_b_c), .fall_c(fall_b_c)
  );

  sensor_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_e (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(emerg_raw),
    .deb(deb_e), .rise_c(rise_e_c), .fall_c(unused_fall_e_c)
  );

  // Hold timers load on the same edge the debounced level falls, so Ta/Tb never dip.
  logic [HW-1:0] hold_a, hold_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        hold_a <= '0;
    else if (rise_a_c)                 hold_a <= '0;
    else if (fall_a_c)                 hold_a <= HW'(HOLD_TICKS);
    else if (tick && hold_a != '0)     hold_a <= hold_a - HW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        hold_b <= '0;
    else if (rise_b_c)                 hold_b <= '0;
    else if (fall_b_c)                 hold_b <= HW'(HOLD_TICKS);
    else if (tick && hold_b != '0)     hold_b <= hold_b - HW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ta <= 1'b0;
      Tb <= 1'b0;
    end else begin
      Ta <= deb_a | (hold_a != '0);
      Tb <= deb_b | (hold_b != '0);
    end
  end

  // Priority FSM runs one cycle behind the debounced emergency edge.
  prio_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          e_rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= P_IDLE;
      timer_q  <= '0;
      e_rise_q <= 1'b0;
      prio     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      e_rise_q <= rise_e_c;
      prio     <= (state_d == P_ACTIVE);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      P_IDLE: begin
        if (e_rise_q) begin
          if (emerg_clr) begin
            state_d = P_REARM;
          end else begin
            state_d = P_ACTIVE;
            timer_d = TW'(PRIO_TICKS);
          end
        end
      end
      P_ACTIVE: begin
        if (emerg_clr) begin
          state_d = P_REARM;
        end else if (tick) begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) state_d = P_REARM;
        end
      end
      P_REARM: begin
        if (!deb_e) state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

`ifdef TRAFFIC_STATS_EN
  // Saturating arrival counters; clear takes precedence over a same-cycle arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cars_a <= '0;
      cars_b <= '0;
    end else if (stats_clr) begin
      cars_a <= '0;
      cars_b <= '0;
    end else begin
      if (rise_a_c && cars_a != {CNT_W{1'b1}}) cars_a <= cars_a + CNT_W'(1);
      if (rise_b_c && cars_b != {CNT_W{1'b1}}) cars_b <= cars_b + CNT_W'(1);
    end
  end

  logic unused_sig;
  assign unused_sig = unused_fall_e_c;
`else
  assign cars_a = '0;
  assign cars_b = '0;

  logic unused_sig;
  assign unused_sig = unused_fall_e_c ^ stats_clr;
`endif

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed scoreboard bench for traffic_sensor_cond (DEB=4, HOLD=3, PRIO=10, tick every 4 clk).
module tb_traffic_sensor_cond;

  localparam int unsigned CNT_W = 2;
`ifdef TRAFFIC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst_n, tick;
  logic det_a_raw, det_b_raw, emerg_raw, emerg_clr, stats_clr;
  logic Ta, Tb, prio;
  logic [CNT_W-1:0] cars_a, cars_b;

  traffic_sensor_cond #(
    .DEB_TICKS(4), .HOLD_TICKS(3), .PRIO_TICKS(10), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .det_a_raw(det_a_raw), .det_b_raw(det_b_raw), .emerg_raw(emerg_raw),
    .emerg_clr(emerg_clr), .stats_clr(stats_clr),
    .Ta(Ta), .Tb(Tb), .prio(prio), .cars_a(cars_a), .cars_b(cars_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] val;  // {Ta, Tb, prio, cars_a, cars_b}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   na = 0;
  int   nb = 0;

  function automatic logic [CNT_W-1:0] sat(input int n);
    if (!STATS) return '0;
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic expect_o(input string tag, input logic ta, input logic tb, input logic pr);
    exp_t e;
    e.tag = tag;
    e.val = {ta, tb, pr, sat(na), sat(nb)};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [6:0] obs;
    obs = {Ta, Tb, prio, cars_a, cars_b};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b (Ta,Tb,prio,cars_a,cars_b)", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    clocks(1);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_pulse();
      clocks(3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0;
    det_a_raw = 1'b0; det_b_raw = 1'b0; emerg_raw = 1'b0;
    emerg_clr = 1'b0; stats_clr = 1'b0;
    clocks(3);
    expect_o("reset", 0, 0, 0); check();
    rst_n = 1'b1;
    clocks(2);

    // Three-tick glitch on A must be rejected
    det_a_raw = 1'b1; clocks(2); ticks(3);
    det_a_raw = 1'b0;
    expect_o("glitch_mid", 0, 0, 0); check();
    clocks(2); ticks(4);
    expect_o("glitch_end", 0, 0, 0); check();

    // A rises after exactly 4 ticks, Ta one cycle later
    det_a_raw = 1'b1; clocks(2); ticks(3);
    expect_o("a_pre", 0, 0, 0); check();
    tick_pulse(); na++;
    expect_o("a_deb_edge", 0, 0, 0); check();
    clocks(1);
    expect_o("a_rise", 1, 0, 0); check();
    clocks(2);

    // A falls; Ta held 3 more ticks
    det_a_raw = 1'b0; clocks(2); ticks(3);
    expect_o("a_fall_pre", 1, 0, 0); check();
    tick_pulse();
    expect_o("a_hold_load", 1, 0, 0); check();
    clocks(1);
    expect_o("a_hold_nodip", 1, 0, 0); check();
    clocks(2); ticks(2);
    expect_o("a_hold2", 1, 0, 0); check();
    tick_pulse();
    expect_o("a_hold_last", 1, 0, 0); check();
    clocks(1);
    expect_o("a_drop", 0, 0, 0); check();
    clocks(2);

    // Emergency held 20 ticks: 10 ticks of priority, no re-trigger
    emerg_raw = 1'b1; clocks(2); ticks(3);
    tick_pulse();
    expect_o("e_deb", 0, 0, 0); check();
    clocks(1);
    expect_o("e_prio_on", 0, 0, 1); check();
    clocks(2); ticks(9);
    expect_o("e_prio_hold", 0, 0, 1); check();
    tick_pulse();
    expect_o("e_timeout", 0, 0, 0); check();
    clocks(3); ticks(6);
    expect_o("e_no_retrig", 0, 0, 0); check();
    emerg_raw = 1'b0; clocks(2); ticks(4);
    emerg_raw = 1'b1; clocks(2); ticks(4);
    expect_o("e_retrig", 0, 0, 1); check();
    emerg_clr = 1'b1; clocks(1); emerg_clr = 1'b0;
    expect_o("e_clr_active", 0, 0, 0); check();
    emerg_raw = 1'b0; clocks(2); ticks(4); clocks(2);
    expect_o("e_idle", 0, 0, 0); check();

    // Clear in the same cycle as the trigger wins
    emerg_raw = 1'b1; clocks(2); ticks(3);
    emerg_clr = 1'b1;
    tick_pulse();
    expect_o("clr_pre_trig", 0, 0, 0); check();
    clocks(1);
    expect_o("clr_race", 0, 0, 0); check();
    clocks(2); emerg_clr = 1'b0;
    ticks(4);
    expect_o("clr_rearm", 0, 0, 0); check();
    emerg_raw = 1'b0; clocks(2); ticks(4); clocks(2);

    // Five B arrivals saturate a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      det_b_raw = 1'b1; clocks(2); ticks(4); nb++;
      expect_o($sformatf("b_arrive%0d", i), 0, 1, 0); check();
      det_b_raw = 1'b0; clocks(2); ticks(7);
      expect_o($sformatf("b_gone%0d", i), 0, 0, 0); check();
    end
    stats_clr = 1'b1; clocks(1); stats_clr = 1'b0;
    na = 0; nb = 0;
    expect_o("stats_clr", 0, 0, 0); check();
    det_b_raw = 1'b1; clocks(2); ticks(3);
    stats_clr = 1'b1;
    tick_pulse();
    stats_clr = 1'b0;
    expect_o("clr_beats_inc", 0, 0, 0); check();
    clocks(3);
    expect_o("clr_beats_inc_tb", 0, 1, 0); check();
    det_b_raw = 1'b0; clocks(2); ticks(7);
    det_b_raw = 1'b1; clocks(2); ticks(4); nb++;
    expect_o("b_after_clr", 0, 1, 0); check();

    // Asynchronous reset mid-operation, then full re-debounce
    det_a_raw = 1'b1; emerg_raw = 1'b1; clocks(2); ticks(4); na++;
    expect_o("pre_rst", 1, 1, 1); check();
    #2 rst_n = 1'b0;
    #1 na = 0; nb = 0;
    expect_o("in_rst", 0, 0, 0); check();
    #3 rst_n = 1'b1;
    clocks(2); ticks(3);
    expect_o("rst_redeb", 0, 0, 0); check();
    tick_pulse(); na++; nb++;
    clocks(1);
    expect_o("rst_rearm", 1, 1, 1); check();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
